// File: rtl/stack_arbiter.sv
// Round-robin arbiter granting N_REQ requesters push/pop access to one shared stack.
// One operation per three cycles: arbitrate (IDLE), strobe the stack (ISSUE), acknowledge (DONE).
module stack_arbiter #(
    parameter int N_REQ    = 4,
    parameter int WORD_LEN = 8
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ-1:0]             op,
    input  logic [N_REQ*WORD_LEN-1:0]    wdata,
    output logic [N_REQ-1:0]             ack,
    output logic [WORD_LEN-1:0]          rdata,
    output logic                         err,
    output logic                         busy,
    output logic [$clog2(N_REQ)-1:0]     owner,
    output logic                         stk_push,
    output logic                         stk_pop,
    output logic [WORD_LEN-1:0]          stk_din,
    input  logic [WORD_LEN-1:0]          stk_dout,
    input  logic                         stk_full,
    input  logic                         stk_empty
);

    localparam int OW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [OW-1:0]        rr_ptr;
    logic [OW-1:0]        rr_nxt;
    logic [OW-1:0]        grant_idx;
    logic [OW-1:0]        cand;
    logic                 grant_vld;
    logic                 op_p0;
    logic [WORD_LEN-1:0]  wdata_p0;
    logic                 refuse_p1;
    logic                 pop_ok_p1;

    // Round-robin search starting at rr_ptr, wrapping at N_REQ
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = OW'((int'(rr_ptr) + k) % N_REQ);
            if (!grant_vld && req[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign rr_nxt = OW'((int'(grant_idx) + 1) % N_REQ);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ack       = '0;
        err       = 1'b0;
        rdata     = '0;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_din   = '0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (grant_vld) state_nxt = ISSUE;
            end
            ISSUE: begin
                state_nxt = DONE;
                stk_push  = !op_p0 && !stk_full;
                stk_pop   = op_p0 && !stk_empty;
                stk_din   = wdata_p0;
            end
            DONE: begin
                state_nxt  = IDLE;
                ack[owner] = 1'b1;
                err        = refuse_p1;
                rdata      = pop_ok_p1 ? stk_dout : '0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // p0: winner latched on the IDLE->ISSUE edge; p1: outcome latched on the ISSUE->DONE edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr    <= '0;
            owner     <= '0;
            op_p0     <= 1'b0;
            refuse_p1 <= 1'b0;
            pop_ok_p1 <= 1'b0;
        end else begin
            if (state == IDLE && grant_vld) begin
                owner  <= grant_idx;
                op_p0  <= op[grant_idx];
                rr_ptr <= rr_nxt;
            end
            if (state == ISSUE) begin
                refuse_p1 <= op_p0 ? stk_empty : stk_full;
                pop_ok_p1 <= op_p0 && !stk_empty;
            end
        end
    end

    // Push data is only observed through stk_din, which is gated by ISSUE
    always_ff @(posedge clk) begin
        if (state == IDLE && grant_vld) begin
            wdata_p0 <= wdata[int'(grant_idx)*WORD_LEN +: WORD_LEN];
        end
    end

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: an 8-deep behavioural stack plus a queue/round-robin reference model.
module tb_stack_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  req;
    logic [3:0]  op;
    logic [31:0] wdata;
    logic [3:0]  ack;
    logic [7:0]  rdata;
    logic        err;
    logic        busy;
    logic [1:0]  owner;
    logic        stk_push;
    logic        stk_pop;
    logic [7:0]  stk_din;
    logic [7:0]  stk_dout = 8'h00;
    logic        stk_full;
    logic        stk_empty;

    int checks   = 0;
    int failures = 0;

    stack_arbiter #(.N_REQ(4), .WORD_LEN(8)) dut (
        .clk(clk), .rstn(rstn), .req(req), .op(op), .wdata(wdata),
        .ack(ack), .rdata(rdata), .err(err), .busy(busy), .owner(owner),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
        .stk_dout(stk_dout), .stk_full(stk_full), .stk_empty(stk_empty)
    );

    always #5 clk = ~clk;

    // Environment stack, depth 8, output registered on the pop edge
    logic [7:0] smem [8];
    logic [3:0] sp = 4'd0;
    logic       stk_clr = 1'b0;
    assign stk_full  = (sp == 4'd8);
    assign stk_empty = (sp == 4'd0);
    always @(posedge clk) begin
        if (stk_clr) begin
            sp <= 4'd0;
        end else if (stk_push && sp < 4'd8) begin
            smem[sp[2:0]] <= stk_din;
            sp <= sp + 4'd1;
        end else if (stk_pop && sp > 4'd0) begin
            stk_dout <= smem[3'(sp - 4'd1)];
            sp <= sp - 4'd1;
        end
    end

    // Reference model: stack contents as a queue, round-robin pointer as an integer
    logic [7:0] ref_q[$];
    int         m_rr = 0;

    function automatic int model_grant(input logic [3:0] pend);
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (m_rr + k) % 4;
            if (pend[idx]) begin
                m_rr = (idx + 1) % 4;
                return idx;
            end
        end
        return -1;
    endfunction

    function automatic void model_op(input logic o, input logic [7:0] d,
                                     output logic e, output logic [7:0] rd);
        e  = 1'b0;
        rd = 8'h00;
        if (!o) begin
            if (ref_q.size() >= 8) e = 1'b1;
            else ref_q.push_back(d);
        end else begin
            if (ref_q.size() == 0) e = 1'b1;
            else rd = ref_q.pop_back();
        end
    endfunction

    task automatic do_reset();
        req     = 4'h0;
        op      = 4'h0;
        wdata   = 32'h0;
        rstn    = 1'b0;
        stk_clr = 1'b1;
        ref_q.delete();
        m_rr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn    = 1'b1;
        stk_clr = 1'b0;
    endtask

    // Drives one request from requester i and captures what the DUT does with it
    task automatic run_op(input int i, input logic o, input logic [7:0] d,
                          output int lat, output int slat, output int who,
                          output logic e, output logic [7:0] rd,
                          output bit saw_push, output bit saw_pop, output logic [7:0] din);
        @(negedge clk);
        req[i] = 1'b1;
        op[i]  = o;
        wdata[i*8 +: 8] = d;
        lat = -1; slat = -1; who = -1;
        e = 1'b0; rd = 8'h00; saw_push = 0; saw_pop = 0; din = 8'h00;
        for (int n = 1; n <= 8 && lat < 0; n++) begin
            @(negedge clk);
            if (stk_push) begin saw_push = 1; din = stk_din; slat = n; end
            if (stk_pop)  begin saw_pop = 1; slat = n; end
            if (ack != 4'h0) begin
                lat = n; e = err; rd = rdata;
                for (int b = 0; b < 4; b++) if (ack[b]) who = b;
            end
        end
        req[i] = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b1; req = 4'h0; op = 4'h0; wdata = 32'h0;
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({ack, err, busy, stk_push, stk_pop} !== 8'h00) begin
            failures++;
            $display("FAIL reset_ctrl got ack=%b err=%b busy=%b push=%b pop=%b want all 0",
                     ack, err, busy, stk_push, stk_pop);
        end
        checks++;
        if ({rdata, stk_din, owner} !== 18'h0) begin
            failures++;
            $display("FAIL reset_data got rdata=%h stk_din=%h owner=%0d want 0", rdata, stk_din, owner);
        end
        do_reset();
    endtask

    task automatic test_push_pop();
        int lat, slat, who; logic e; logic [7:0] rd, din; bit sp_, so_;
        do_reset();
        run_op(0, 1'b0, 8'hA5, lat, slat, who, e, rd, sp_, so_, din);
        checks++;
        if (lat !== 2 || slat !== 1 || who !== 0) begin
            failures++;
            $display("FAIL push_timing got lat=%0d strobe=%0d who=%0d want 2 1 0", lat, slat, who);
        end
        checks++;
        if (!sp_ || din !== 8'hA5 || e !== 1'b0) begin
            failures++;
            $display("FAIL push_data got push=%0d din=%h err=%b want 1 a5 0", sp_, din, e);
        end
        run_op(0, 1'b1, 8'h00, lat, slat, who, e, rd, sp_, so_, din);
        checks++;
        if (lat !== 2 || slat !== 1 || !so_ || sp_) begin
            failures++;
            $display("FAIL pop_timing got lat=%0d strobe=%0d pop=%0d push=%0d want 2 1 1 0", lat, slat, so_, sp_);
        end
        checks++;
        if (rd !== 8'hA5 || e !== 1'b0) begin
            failures++;
            $display("FAIL pop_data got rdata=%h err=%b want a5 0", rd, e);
        end
    endtask

    task automatic test_pop_empty();
        int lat, slat, who; logic e; logic [7:0] rd, din; bit sp_, so_;
        do_reset();
        run_op(2, 1'b1, 8'h00, lat, slat, who, e, rd, sp_, so_, din);
        checks++;
        if (so_ || sp_) begin
            failures++;
            $display("FAIL pop_empty_strobe got pop=%0d push=%0d want 0 0", so_, sp_);
        end
        checks++;
        if (lat !== 2 || who !== 2 || e !== 1'b1 || rd !== 8'h00) begin
            failures++;
            $display("FAIL pop_empty_ack got lat=%0d who=%0d err=%b rdata=%h want 2 2 1 00", lat, who, e, rd);
        end
    endtask

    task automatic test_round_robin();
        int exp_ord[5];
        int got = 0;
        logic [7:0] din_last = 8'h00;
        do_reset();
        for (int i = 0; i < 4; i++) wdata[i*8 +: 8] = 8'($urandom);
        for (int k = 0; k < 5; k++) exp_ord[k] = model_grant(4'hF);
        op  = 4'h0;
        req = 4'hF;
        for (int n = 1; n <= 20 && got < 5; n++) begin
            @(negedge clk);
            if (stk_push) din_last = stk_din;
            if (ack != 4'h0) begin
                checks++;
                if (ack !== 4'(1 << exp_ord[got]) || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL rr_order[%0d] got ack=%b busy=%b want ack=%b busy=1",
                             got, ack, busy, 4'(1 << exp_ord[got]));
                end
                checks++;
                if (din_last !== wdata[exp_ord[got]*8 +: 8]) begin
                    failures++;
                    $display("FAIL rr_din[%0d] got %h want %h", got, din_last, wdata[exp_ord[got]*8 +: 8]);
                end
                checks++;
                if (n !== 2 + 3*got) begin
                    failures++;
                    $display("FAIL rr_spacing[%0d] got cycle %0d want %0d", got, n, 2 + 3*got);
                end
                got++;
            end
        end
        req = 4'h0;
        checks++;
        if (got !== 5) begin
            failures++;
            $display("FAIL rr_count got %0d acks want 5", got);
        end
    endtask

    task automatic test_full();
        int lat, slat, who; logic e; logic [7:0] rd, din; bit sp_, so_;
        logic [7:0] eighth = 8'h00;
        int errs = 0;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            eighth = 8'($urandom);
            run_op(int'($urandom_range(0, 3)), 1'b0, eighth, lat, slat, who, e, rd, sp_, so_, din);
            if (e !== 1'b0 || !sp_) errs++;
        end
        checks++;
        if (errs !== 0) begin
            failures++;
            $display("FAIL fill_pushes got %0d refused want 0", errs);
        end
        run_op(1, 1'b0, 8'h55, lat, slat, who, e, rd, sp_, so_, din);
        checks++;
        if (lat !== 2 || e !== 1'b1 || sp_ || so_) begin
            failures++;
            $display("FAIL push_full got lat=%0d err=%b push=%0d pop=%0d want 2 1 0 0", lat, e, sp_, so_);
        end
        run_op(3, 1'b1, 8'h00, lat, slat, who, e, rd, sp_, so_, din);
        checks++;
        if (rd !== eighth || e !== 1'b0) begin
            failures++;
            $display("FAIL pop_after_full got rdata=%h err=%b want %h 0", rd, e, eighth);
        end
    endtask

    task automatic test_lifo();
        int lat, slat, who; logic e; logic [7:0] rd, din; bit sp_, so_;
        do_reset();
        run_op(1, 1'b0, 8'h11, lat, slat, who, e, rd, sp_, so_, din);
        run_op(3, 1'b0, 8'h33, lat, slat, who, e, rd, sp_, so_, din);
        run_op(0, 1'b1, 8'h00, lat, slat, who, e, rd, sp_, so_, din);
        checks++;
        if (rd !== 8'h33 || who !== 0) begin
            failures++;
            $display("FAIL lifo_first got rdata=%h who=%0d want 33 0", rd, who);
        end
        run_op(0, 1'b1, 8'h00, lat, slat, who, e, rd, sp_, so_, din);
        checks++;
        if (rd !== 8'h11 || e !== 1'b0) begin
            failures++;
            $display("FAIL lifo_second got rdata=%h err=%b want 11 0", rd, e);
        end
    endtask

    task automatic test_reset_issue();
        int lat, slat, who; logic e; logic [7:0] rd, din; bit sp_, so_;
        bit seen = 0;
        int first_who = -1;
        int first_n = -1;
        do_reset();
        // Requester 0 moves the pointer to 1, so 1 beats 3 in the aborted round
        run_op(0, 1'b0, 8'h5A, lat, slat, who, e, rd, sp_, so_, din);
        @(negedge clk);
        op = 4'h0;
        wdata[1*8 +: 8] = 8'hC1;
        wdata[3*8 +: 8] = 8'hC3;
        req = 4'b1010;
        for (int n = 0; n < 6 && !seen; n++) begin
            @(negedge clk);
            if (stk_push) seen = 1;
        end
        checks++;
        if (!seen || owner !== 2'd1) begin
            failures++;
            $display("FAIL abort_setup got push_seen=%0d owner=%0d want 1 1", seen, owner);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if ({stk_push, stk_pop, busy, ack, err} !== 8'h00 || stk_din !== 8'h00 || owner !== 2'd0) begin
            failures++;
            $display("FAIL abort_outputs got push=%b pop=%b busy=%b ack=%b err=%b din=%h owner=%0d want all 0",
                     stk_push, stk_pop, busy, ack, err, stk_din, owner);
        end
        @(negedge clk);
        rstn = 1'b1;
        for (int n = 1; n <= 8 && first_who < 0; n++) begin
            @(negedge clk);
            if (ack != 4'h0) begin
                first_n = n;
                for (int b = 0; b < 4; b++) if (ack[b]) first_who = b;
            end
        end
        req = 4'h0;
        checks++;
        if (first_who !== 1 || first_n !== 2) begin
            failures++;
            $display("FAIL abort_regrant got who=%0d cycle=%0d want 1 2", first_who, first_n);
        end
    endtask

    task automatic test_random();
        logic [3:0] mask, pend;
        logic e;
        logic [7:0] rd, din_seen;
        bit pushed;
        int w, cyc;
        do_reset();
        for (int r = 0; r < 40; r++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) begin
                    op[i] = 1'($urandom);
                    wdata[i*8 +: 8] = 8'($urandom);
                end
            end
            req = mask;
            pend = mask;
            cyc = 0;
            pushed = 0;
            din_seen = 8'h00;
            while (pend != 4'h0 && cyc < 30) begin
                @(negedge clk);
                cyc++;
                if (stk_push) begin pushed = 1; din_seen = stk_din; end
                if (ack != 4'h0) begin
                    w = model_grant(pend);
                    model_op(op[w], wdata[w*8 +: 8], e, rd);
                    checks++;
                    if (ack !== 4'(1 << w) || err !== e || rdata !== rd) begin
                        failures++;
                        $display("FAIL rand[%0d] got ack=%b err=%b rdata=%h want ack=%b err=%b rdata=%h",
                                 r, ack, err, rdata, 4'(1 << w), e, rd);
                    end
                    checks++;
                    if (pushed !== (!op[w] && !e) || (pushed && din_seen !== wdata[w*8 +: 8])) begin
                        failures++;
                        $display("FAIL rand_push[%0d] got push=%0d din=%h want push=%0d din=%h",
                                 r, pushed, din_seen, (!op[w] && !e), wdata[w*8 +: 8]);
                    end
                    pend[w] = 1'b0;
                    req[w]  = 1'b0;
                    pushed  = 0;
                end
            end
            if (pend != 4'h0) begin
                checks++;
                failures++;
                $display("FAIL rand_timeout[%0d] got pending=%b want 0000", r, pend);
                req = 4'h0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_pop_empty();
        test_round_robin();
        test_full();
        test_lifo();
        test_reset_issue();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
